// File: rtl/sdram_sched_pkg.sv
// -----------------------------------------------------------------------------
// sdram_sched_pkg
// Shared SDRAM types for the command scheduler:
//   cmd_t         command opcodes understood by the IO engine
//   d_t / data_t  command FIFO word {cmd, ba, d{column, data}}
//   addr_t        requester address {ba, row, col}
//   sched_state_t scheduler FSM states
//   TAG_W         width of the read tag carried in d.data of a READ
// -----------------------------------------------------------------------------
package sdram_sched_pkg;

  localparam int SD_BA_W   = 2;
  localparam int SD_ROW_W  = 13;
  localparam int SD_COL_W  = 9;
  localparam int SD_DATA_W = 16;
  localparam int SD_BANKS  = 1 << SD_BA_W;
  localparam int TAG_W     = 2;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_ACT   = 3'd1,
    CMD_READ  = 3'd2,
    CMD_WRITE = 3'd3,
    CMD_PRE   = 3'd4,
    CMD_PALL  = 3'd5,
    CMD_REF   = 3'd6,
    CMD_MRS   = 3'd7
  } cmd_t;

  typedef struct packed {
    logic [SD_COL_W-1:0]  column;
    logic [SD_DATA_W-1:0] data;
  } d_t;

  typedef struct packed {
    cmd_t               cmd;
    logic [SD_BA_W-1:0] ba;
    d_t                 d;
  } data_t;

  typedef struct packed {
    logic [SD_BA_W-1:0]  ba;
    logic [SD_ROW_W-1:0] row;
    logic [SD_COL_W-1:0] col;
  } addr_t;

  typedef enum logic [3:0] {
    S_INIT_WAIT,
    S_INIT_PALL,
    S_INIT_REF,
    S_INIT_MRS,
    S_IDLE,
    S_REF_PALL,
    S_REF_REF,
    S_PRE,
    S_ACT,
    S_RW
  } sched_state_t;

endpackage

// File: rtl/sdram_sched_if.sv
// -----------------------------------------------------------------------------
// sdram_sched_if
// Bus between requesters / command FIFO and the scheduler.
//   fifo_full  FIFO full flag          fifo_wrreq  FIFO write strobe
//   fifo_in    FIFO command word       req/we      per-port request, 1=write
//   addr       per-port {ba,row,col}   wdata       per-port write data
//   ack        per-port accept pulse
// master: requester/FIFO side.  slave: the scheduler.
// -----------------------------------------------------------------------------
interface sdram_sched_if
  import sdram_sched_pkg::*;
#(
  parameter int PORTS = 4
);
  logic                             fifo_full;
  logic                             fifo_wrreq;
  data_t                            fifo_in;
  logic  [PORTS-1:0]                req;
  logic  [PORTS-1:0]                we;
  addr_t [PORTS-1:0]                addr;
  logic  [PORTS-1:0][SD_DATA_W-1:0] wdata;
  logic  [PORTS-1:0]                ack;

  modport master (
    output fifo_full, req, we, addr, wdata,
    input  fifo_wrreq, fifo_in, ack
  );

  modport slave (
    input  fifo_full, req, we, addr, wdata,
    output fifo_wrreq, fifo_in, ack
  );
endinterface

// File: rtl/sdram_rr_arb.sv
// -----------------------------------------------------------------------------
// sdram_rr_arb
// PORTS-wide round-robin arbiter. The search starts just after the last
// granted port and wraps modulo PORTS.
//   clkSDRAM, n_reset  clock, async active-low reset
//   req_i              request vector
//   advance_i          grant taken this cycle: pointer moves to idx_o
//   grant_o            one-hot grant (all zero when no request)
//   idx_o              index of the granted port
// -----------------------------------------------------------------------------
module sdram_rr_arb #(
  parameter int PORTS = 4,
  parameter int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clkSDRAM,
  input  logic             n_reset,
  input  logic [PORTS-1:0] req_i,
  input  logic             advance_i,
  output logic [PORTS-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] ptr_q;

  always_ff @(posedge clkSDRAM or negedge n_reset) begin
    if (!n_reset) begin
      ptr_q <= IDX_W'(PORTS - 1);
    end else if (advance_i) begin
      ptr_q <= idx_o;
    end
  end

  always_comb begin
    int   p;
    logic found;
    p       = 0;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    // Offsets 1..PORTS visit every port once, the last granted port last.
    for (int k = 1; k <= PORTS; k++) begin
      p = (int'(ptr_q) + k) % PORTS;
      if (!found && req_i[p]) begin
        found      = 1'b1;
        grant_o[p] = 1'b1;
        idx_o      = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/sdram_sched.sv
// -----------------------------------------------------------------------------
// sdram_sched
// Orders commands into the SDRAM IO engine's command FIFO: power-up sequence
// (PALL, INIT_REF x REF, MRS), periodic auto-refresh, and round-robin access
// with per-bank open-row tracking (PRE/ACT only when needed). Timing between
// commands is enforced downstream.
//   clkSDRAM   clock               n_reset    async active-low reset
//   icnt_ovf   IO-engine tick      init_done  initialisation complete
//   bus        sdram_sched_if.slave (FIFO write side + requester ports)
// -----------------------------------------------------------------------------
module sdram_sched
  import sdram_sched_pkg::*;
#(
  parameter int PORTS    = 4,
  parameter int INIT_REF = 2,
  parameter int ROW_W    = SD_ROW_W,
  parameter int COL_W    = SD_COL_W
) (
  input  logic         clkSDRAM,
  input  logic         n_reset,
  input  logic         icnt_ovf,
  output logic         init_done,
  sdram_sched_if.slave bus
);

  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int RC_W  = (INIT_REF > 1) ? $clog2(INIT_REF) : 1;

  sched_state_t        state_q, state_d;
  logic [RC_W-1:0]     refcnt_q, refcnt_d;
  logic                pend_q, pend_d;
  logic [SD_BANKS-1:0] open_q, open_d;
  logic                init_q, init_d;
  logic [ROW_W-1:0]    row_q [SD_BANKS];

  // Latched access of the granted port
  logic [IDX_W-1:0]     port_q;
  logic                 we_q;
  addr_t                addr_q;
  logic [SD_DATA_W-1:0] wdata_q;

  logic [PORTS-1:0]   grant;
  logic [IDX_W-1:0]   gidx;
  logic               gnt_any;
  logic               adv;
  logic               have_cmd;
  logic               room;
  logic               wrreq;
  data_t              cmd_word;
  logic [PORTS-1:0]   ack_c;
  logic [SD_BA_W-1:0] gba;

  sdram_rr_arb #(.PORTS(PORTS), .IDX_W(IDX_W)) u_arb (
    .clkSDRAM  (clkSDRAM),
    .n_reset   (n_reset),
    .req_i     (bus.req),
    .advance_i (adv),
    .grant_o   (grant),
    .idx_o     (gidx)
  );

  assign gnt_any = |grant;
  assign gba     = bus.addr[gidx].ba;
  assign room    = !bus.fifo_full;

  // ---- control state ----
  always_ff @(posedge clkSDRAM or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= S_INIT_WAIT;
      refcnt_q <= '0;
      pend_q   <= 1'b0;
      open_q   <= '0;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      refcnt_q <= refcnt_d;
      pend_q   <= pend_d;
      open_q   <= open_d;
      init_q   <= init_d;
    end
  end

  // ---- datapath registers (no reset; qualified by control) ----
  always_ff @(posedge clkSDRAM) begin
    if (adv) begin
      port_q  <= gidx;
      we_q    <= bus.we[gidx];
      addr_q  <= bus.addr[gidx];
      wdata_q <= bus.wdata[gidx];
    end
    if (state_q == S_ACT && room) begin
      row_q[addr_q.ba] <= addr_q.row[ROW_W-1:0];
    end
  end

  // ---- next state and command word ----
  always_comb begin
    state_d  = state_q;
    refcnt_d = refcnt_q;
    pend_d   = pend_q;
    open_d   = open_q;
    init_d   = init_q;
    cmd_word = '0;
    cmd_word.cmd = CMD_NOP;
    ack_c    = '0;
    adv      = 1'b0;
    have_cmd = 1'b0;

    // Ticks while a refresh is already pending collapse into that one.
    if (icnt_ovf && init_q) pend_d = 1'b1;

    case (state_q)
      S_INIT_WAIT: begin
        if (icnt_ovf) state_d = S_INIT_PALL;
      end
      S_INIT_PALL: begin
        have_cmd     = 1'b1;
        cmd_word.cmd = CMD_PALL;
        if (room) begin
          state_d  = S_INIT_REF;
          refcnt_d = '0;
        end
      end
      S_INIT_REF: begin
        have_cmd     = 1'b1;
        cmd_word.cmd = CMD_REF;
        if (room) begin
          if (refcnt_q == RC_W'(INIT_REF - 1)) state_d = S_INIT_MRS;
          else refcnt_d = refcnt_q + 1'b1;
        end
      end
      S_INIT_MRS: begin
        // Mode bits come from the IO engine; d stays zero.
        have_cmd     = 1'b1;
        cmd_word.cmd = CMD_MRS;
        if (room) begin
          state_d = S_IDLE;
          init_d  = 1'b1;
        end
      end
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_REF_PALL;
        end else if (gnt_any) begin
          adv = 1'b1;
          if (!open_q[gba]) state_d = S_ACT;
          else if (row_q[gba] == bus.addr[gidx].row[ROW_W-1:0]) state_d = S_RW;
          else state_d = S_PRE;
        end
      end
      S_REF_PALL: begin
        have_cmd     = 1'b1;
        cmd_word.cmd = CMD_PALL;
        if (room) begin
          state_d = S_REF_REF;
          open_d  = '0;
        end
      end
      S_REF_REF: begin
        have_cmd     = 1'b1;
        cmd_word.cmd = CMD_REF;
        if (room) begin
          state_d = S_IDLE;
          open_d  = '0;
          pend_d  = 1'b0;
        end
      end
      S_PRE: begin
        have_cmd     = 1'b1;
        cmd_word.cmd = CMD_PRE;
        cmd_word.ba  = addr_q.ba;
        if (room) begin
          state_d             = S_ACT;
          open_d[addr_q.ba]   = 1'b0;
        end
      end
      S_ACT: begin
        have_cmd     = 1'b1;
        cmd_word.cmd = CMD_ACT;
        cmd_word.ba  = addr_q.ba;
        cmd_word.d.data[ROW_W-1:0] = addr_q.row[ROW_W-1:0];
        if (room) begin
          state_d           = S_RW;
          open_d[addr_q.ba] = 1'b1;
        end
      end
      S_RW: begin
        have_cmd              = 1'b1;
        cmd_word.ba           = addr_q.ba;
        cmd_word.d.column     = addr_q.col[COL_W-1:0];
        if (we_q) begin
          cmd_word.cmd    = CMD_WRITE;
          cmd_word.d.data = wdata_q;
        end else begin
          // Read tag: port index in the low bits, rest zero.
          cmd_word.cmd                = CMD_READ;
          cmd_word.d.data[TAG_W-1:0]  = TAG_W'(port_q);
        end
        if (room) begin
          state_d       = S_IDLE;
          ack_c[port_q] = 1'b1;
        end
      end
      default: state_d = S_INIT_WAIT;
    endcase

    wrreq = have_cmd && room;
  end

  assign bus.fifo_wrreq = wrreq;
  assign bus.fifo_in    = cmd_word;
  assign bus.ack        = ack_c;
  assign init_done      = init_q;

endmodule

// File: tb/tb_sdram_sched.sv
// -----------------------------------------------------------------------------
// tb_sdram_sched
// Directed bench for sdram_sched: FIFO writes are captured on the falling
// edge together with the ack vector; each scenario task checks the captured
// words against hand-computed command words.
// -----------------------------------------------------------------------------
module tb_sdram_sched;
  import sdram_sched_pkg::*;

  logic clkSDRAM = 1'b0;
  logic n_reset  = 1'b0;
  logic icnt_ovf = 1'b0;
  logic init_done;

  always #5 clkSDRAM = ~clkSDRAM;

  sdram_sched_if #(.PORTS(4)) bus ();

  sdram_sched #(.PORTS(4), .INIT_REF(2), .ROW_W(13), .COL_W(9)) dut (
    .clkSDRAM  (clkSDRAM),
    .n_reset   (n_reset),
    .icnt_ovf  (icnt_ovf),
    .init_done (init_done),
    .bus       (bus)
  );

  typedef struct packed {
    data_t      w;
    logic [3:0] a;
  } ent_t;

  ent_t mon_q[$];
  int   stray_ack    = 0;
  int   early_ack    = 0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always @(negedge clkSDRAM) begin
    if (n_reset) begin
      if (bus.fifo_wrreq) mon_q.push_back({bus.fifo_in, bus.ack});
      if (|bus.ack && !bus.fifo_wrreq) stray_ack++;
      if (|bus.ack && !init_done) early_ack++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  function automatic ent_t ex(cmd_t c, logic [1:0] ba, logic [8:0] col,
                              logic [15:0] d, logic [3:0] a);
    ent_t e;
    e.w.cmd      = c;
    e.w.ba       = ba;
    e.w.d.column = col;
    e.w.d.data   = d;
    e.a          = a;
    return e;
  endfunction

  function automatic ent_t pop_ent();
    ent_t e;
    e = 'x;
    if (mon_q.size() > 0) e = mon_q.pop_front();
    return e;
  endfunction

  task automatic wait_q(input int n);
    for (int c = 0; c < 300 && mon_q.size() < n; c++) @(posedge clkSDRAM);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clkSDRAM);
    #1;
  endtask

  task automatic set_port(input int p, input logic w, input logic [1:0] ba,
                          input logic [12:0] row, input logic [8:0] col,
                          input logic [15:0] wd);
    bus.we[p]       = w;
    bus.addr[p].ba  = ba;
    bus.addr[p].row = row;
    bus.addr[p].col = col;
    bus.wdata[p]    = wd;
  endtask

  task automatic do_req(input int p, input logic w, input logic [1:0] ba,
                        input logic [12:0] row, input logic [8:0] col,
                        input logic [15:0] wd);
    set_port(p, w, ba, row, col, wd);
    bus.req[p] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clkSDRAM);
      if (bus.ack[p]) break;
    end
    @(posedge clkSDRAM);
    #1;
    bus.req[p] = 1'b0;
  endtask

  task automatic test_reset();
    bus.fifo_full = 1'b0;
    bus.req       = '0;
    bus.we        = '0;
    bus.addr      = '0;
    bus.wdata     = '0;
    n_reset       = 1'b0;
    cycles(3);
    n_reset = 1'b1;
    @(negedge clkSDRAM);
    tests_run++;
    if (bus.fifo_wrreq !== 1'b0) begin
      tests_failed++; $display("FAIL reset_wrreq: got %b want 0", bus.fifo_wrreq);
    end
    tests_run++;
    if (bus.fifo_in !== data_t'('0)) begin
      tests_failed++; $display("FAIL reset_fifo_in: got %h want 0 (NOP)", bus.fifo_in);
    end
    tests_run++;
    if (bus.ack !== 4'b0) begin
      tests_failed++; $display("FAIL reset_ack: got %b want 0000", bus.ack);
    end
    tests_run++;
    if (init_done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_init_done: got %b want 0", init_done);
    end
  endtask

  task automatic test_init();
    ent_t exp [6];
    ent_t g;
    exp[0] = ex(CMD_PALL, 2'd0, 9'h0, 16'h0, 4'b0000);
    exp[1] = ex(CMD_REF,  2'd0, 9'h0, 16'h0, 4'b0000);
    exp[2] = ex(CMD_REF,  2'd0, 9'h0, 16'h0, 4'b0000);
    exp[3] = ex(CMD_MRS,  2'd0, 9'h0, 16'h0, 4'b0000);
    exp[4] = ex(CMD_ACT,  2'd0, 9'h0, 16'h0, 4'b0000);
    exp[5] = ex(CMD_READ, 2'd0, 9'h0, 16'h0, 4'b0001);
    set_port(0, 1'b0, 2'd0, 13'h0, 9'h0, 16'h0);
    bus.req[0] = 1'b1;
    cycles(16);
    tests_run++;
    if (mon_q.size() != 0) begin
      tests_failed++; $display("FAIL init_wait_quiet: got %0d writes want 0", mon_q.size());
    end
    icnt_ovf = 1'b1;
    cycles(1);
    icnt_ovf = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clkSDRAM);
      if (bus.ack[0]) break;
    end
    @(posedge clkSDRAM);
    #1;
    bus.req[0] = 1'b0;
    wait_q(6);
    for (int i = 0; i < 6; i++) begin
      g = pop_ent();
      tests_run++;
      if (g !== exp[i]) begin
        tests_failed++; $display("FAIL init_word%0d: got %h want %h", i, g, exp[i]);
      end
    end
    tests_run++;
    if (init_done !== 1'b1) begin
      tests_failed++; $display("FAIL init_done_high: got %b want 1", init_done);
    end
    tests_run++;
    if (early_ack != 0) begin
      tests_failed++; $display("FAIL ack_before_init: got %0d want 0", early_ack);
    end
  endtask

  task automatic test_read_closed();
    ent_t exp [2];
    ent_t g;
    exp[0] = ex(CMD_ACT,  2'd2, 9'h000, 16'h0123, 4'b0000);
    exp[1] = ex(CMD_READ, 2'd2, 9'h045, 16'h0001, 4'b0010);
    do_req(1, 1'b0, 2'd2, 13'h123, 9'h045, 16'h0);
    wait_q(2);
    for (int i = 0; i < 2; i++) begin
      g = pop_ent();
      tests_run++;
      if (g !== exp[i]) begin
        tests_failed++; $display("FAIL read_closed%0d: got %h want %h", i, g, exp[i]);
      end
    end
  endtask

  task automatic test_write_hit();
    ent_t exp;
    ent_t g;
    exp = ex(CMD_WRITE, 2'd2, 9'h010, 16'hBEEF, 4'b0001);
    do_req(0, 1'b1, 2'd2, 13'h123, 9'h010, 16'hBEEF);
    cycles(3);
    g = pop_ent();
    tests_run++;
    if (g !== exp) begin
      tests_failed++; $display("FAIL write_hit: got %h want %h", g, exp);
    end
    tests_run++;
    if (mon_q.size() != 0) begin
      tests_failed++; $display("FAIL write_hit_extra: got %0d words want 0", mon_q.size());
    end
  endtask

  task automatic test_refresh_during_pre();
    ent_t exp [7];
    ent_t g;
    bit   pulsed;
    exp[0] = ex(CMD_PRE,  2'd2, 9'h000, 16'h0000, 4'b0000);
    exp[1] = ex(CMD_ACT,  2'd2, 9'h000, 16'h0124, 4'b0000);
    exp[2] = ex(CMD_READ, 2'd2, 9'h007, 16'h0002, 4'b0100);
    exp[3] = ex(CMD_PALL, 2'd0, 9'h000, 16'h0000, 4'b0000);
    exp[4] = ex(CMD_REF,  2'd0, 9'h000, 16'h0000, 4'b0000);
    exp[5] = ex(CMD_ACT,  2'd2, 9'h000, 16'h0124, 4'b0000);
    exp[6] = ex(CMD_READ, 2'd2, 9'h020, 16'h0003, 4'b1000);
    pulsed = 1'b0;
    set_port(2, 1'b0, 2'd2, 13'h124, 9'h007, 16'h0);
    bus.req[2] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clkSDRAM);
      if (icnt_ovf) icnt_ovf = 1'b0;
      if (!pulsed && bus.fifo_wrreq && bus.fifo_in.cmd == CMD_PRE) begin
        icnt_ovf = 1'b1;
        pulsed   = 1'b1;
      end
      if (bus.ack[2]) break;
    end
    @(posedge clkSDRAM);
    #1;
    bus.req[2] = 1'b0;
    icnt_ovf   = 1'b0;
    tests_run++;
    if (pulsed !== 1'b1) begin
      tests_failed++; $display("FAIL pre_seen: got %b want 1", pulsed);
    end
    wait_q(5);
    do_req(3, 1'b0, 2'd2, 13'h124, 9'h020, 16'h0);
    wait_q(7);
    for (int i = 0; i < 7; i++) begin
      g = pop_ent();
      tests_run++;
      if (g !== exp[i]) begin
        tests_failed++; $display("FAIL refresh_pre%0d: got %h want %h", i, g, exp[i]);
      end
    end
  endtask

  task automatic test_fifo_full();
    ent_t exp [2];
    ent_t g;
    int   wr_full;
    data_t held;
    exp[0] = ex(CMD_ACT,  2'd1, 9'h000, 16'h0055, 4'b0000);
    exp[1] = ex(CMD_READ, 2'd1, 9'h0AA, 16'h0001, 4'b0010);
    wr_full = 0;
    held    = '0;
    set_port(1, 1'b0, 2'd1, 13'h055, 9'h0AA, 16'h0);
    bus.req[1] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clkSDRAM);
      if (bus.fifo_wrreq && bus.fifo_in.cmd == CMD_ACT) break;
    end
    @(posedge clkSDRAM);
    #1;
    bus.fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clkSDRAM);
      if (bus.fifo_wrreq) wr_full++;
      held = bus.fifo_in;
    end
    @(posedge clkSDRAM);
    #1;
    bus.fifo_full = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clkSDRAM);
      if (bus.ack[1]) break;
    end
    @(posedge clkSDRAM);
    #1;
    bus.req[1] = 1'b0;
    tests_run++;
    if (wr_full != 0) begin
      tests_failed++; $display("FAIL full_no_write: got %0d writes want 0", wr_full);
    end
    tests_run++;
    if (held !== exp[1].w) begin
      tests_failed++; $display("FAIL full_hold_word: got %h want %h", held, exp[1].w);
    end
    wait_q(2);
    for (int i = 0; i < 2; i++) begin
      g = pop_ent();
      tests_run++;
      if (g !== exp[i]) begin
        tests_failed++; $display("FAIL full_word%0d: got %h want %h", i, g, exp[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    ent_t exp [4];
    ent_t g;
    logic [3:0] a;
    exp[0] = ex(CMD_READ, 2'd1, 9'h102, 16'h0002, 4'b0100);
    exp[1] = ex(CMD_READ, 2'd1, 9'h103, 16'h0003, 4'b1000);
    exp[2] = ex(CMD_READ, 2'd1, 9'h100, 16'h0000, 4'b0001);
    exp[3] = ex(CMD_READ, 2'd1, 9'h101, 16'h0001, 4'b0010);
    for (int p = 0; p < 4; p++) set_port(p, 1'b0, 2'd1, 13'h055, 9'(9'h100 + p), 16'h0);
    bus.req = 4'b1111;
    for (int c = 0; c < 200 && bus.req != 4'b0; c++) begin
      @(negedge clkSDRAM);
      a = bus.ack;
      @(posedge clkSDRAM);
      #1;
      bus.req = bus.req & ~a;
    end
    wait_q(4);
    for (int i = 0; i < 4; i++) begin
      g = pop_ent();
      tests_run++;
      if (g !== exp[i]) begin
        tests_failed++; $display("FAIL rr_order%0d: got %h want %h", i, g, exp[i]);
      end
    end
    tests_run++;
    if (stray_ack != 0) begin
      tests_failed++; $display("FAIL ack_without_write: got %0d want 0", stray_ack);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_read_closed();
    test_write_hit();
    test_refresh_during_pre();
    test_fifo_full();
    test_round_robin();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
